sfixed_mult_pipe: RTL and testbench

- Pipelined, multi-channel signed fixed-point multiplier; the successor to the fixed 3-lane 9x9 combinational multiplier.
- CHANNELS independent lanes, each computing out[i] = a[i]*b[i].
- Supports arbitrary Q-formats, a runtime-selectable rounding mode and a runtime-selectable saturate/wrap mode.
- Sits between the vector register read stage and writeback; uses a valid/ready handshake so the datapath can stall it.

---
 rtl/sfixed_mult_pipe.sv | 157 +++++++++++++++
 tb/tb_sfixed_mult_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfixed_mult_pipe.sv
// Multi-lane signed fixed-point multiplier with a stallable valid pipeline.
// Per-beat rounding (half up / truncate) and saturate/wrap to the output Q-format.
module sfixed_mult_pipe #(
    parameter int CHANNELS    = 3,
    parameter int A_LEFT      = 3,
    parameter int A_RIGHT     = 4,
    parameter int B_LEFT      = 3,
    parameter int B_RIGHT     = 4,
    parameter int OUT_LEFT    = 7,
    parameter int OUT_RIGHT   = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*(A_LEFT+A_RIGHT+1)-1:0] a,
    input  logic [CHANNELS*(B_LEFT+B_RIGHT+1)-1:0] b,
    input  logic                         round_en,
    input  logic                         sat_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*(OUT_LEFT+OUT_RIGHT+1)-1:0] out,
    output logic [CHANNELS-1:0]          sat_flag,
    output logic [CHANNELS-1:0]          sat_sticky,
    input  logic                         sticky_clr
);

    localparam int A_W    = A_LEFT + A_RIGHT + 1;
    localparam int B_W    = B_LEFT + B_RIGHT + 1;
    localparam int O_W    = OUT_LEFT + OUT_RIGHT + 1;
    localparam int P_W    = A_W + B_W;
    localparam int D      = A_RIGHT + B_RIGHT - OUT_RIGHT;
    localparam int MID    = PIPE_STAGES - 1;
    localparam int S_W    = P_W + 1;
    localparam int X_W    = ((S_W > O_W) ? S_W : O_W) + 1;
    localparam int RND_SH = (D > 0) ? D - 1 : 0;

    localparam logic signed [S_W-1:0] RND_INC = (D > 0) ? (S_W'(1) << RND_SH) : '0;
    localparam logic signed [X_W-1:0] MAX_X   = {{(X_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
    localparam logic signed [X_W-1:0] MIN_X   = {{(X_W-O_W+1){1'b1}}, {(O_W-1){1'b0}}};
    localparam logic [O_W-1:0]        MAX_O   = {1'b0, {(O_W-1){1'b1}}};
    localparam logic [O_W-1:0]        MIN_O   = {1'b1, {(O_W-1){1'b0}}};

    typedef logic signed [P_W-1:0] prod_t;

    // Stages 1..MID carry raw products; the final stage carries formatted results.
    logic [MID-1:0]  vld_d, vld_q;
    logic [MID-1:0]  rnd_d, rnd_q;
    logic [MID-1:0]  sat_d, sat_q;
    prod_t           prod_d [MID][CHANNELS];
    prod_t           prod_q [MID][CHANNELS];

    logic                             out_valid_d, out_valid_q;
    logic [CHANNELS-1:0][O_W-1:0]     res_d, res_q;
    logic [CHANNELS-1:0]              flag_d, flag_q;
    logic [CHANNELS-1:0]              sticky_d, sticky_q;
    logic                             adv;

    logic signed [A_W-1:0] a_l;
    logic signed [B_W-1:0] b_l;
    logic signed [S_W-1:0] r_v;
    logic signed [S_W-1:0] s_v;
    logic signed [X_W-1:0] x_v;

    always_comb begin
        adv         = !out_valid_q || out_ready;
        vld_d       = vld_q;
        rnd_d       = rnd_q;
        sat_d       = sat_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flag_d      = flag_q;
        a_l         = '0;
        b_l         = '0;
        r_v         = '0;
        s_v         = '0;
        x_v         = '0;

        if (adv) begin
            vld_d[0] = in_valid;
            rnd_d[0] = round_en;
            sat_d[0] = sat_en;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                a_l = a[ch*A_W +: A_W];
                b_l = b[ch*B_W +: B_W];
                prod_d[0][ch] = prod_t'(a_l) * prod_t'(b_l);
            end

            for (int s = 1; s < MID; s++) begin
                vld_d[s]  = vld_q[s-1];
                rnd_d[s]  = rnd_q[s-1];
                sat_d[s]  = sat_q[s-1];
                prod_d[s] = prod_q[s-1];
            end

            out_valid_d = vld_q[MID-1];
            for (int ch = 0; ch < CHANNELS; ch++) begin
                // One extra bit so the rounding increment can never overflow.
                r_v = {prod_q[MID-1][ch][P_W-1], prod_q[MID-1][ch]};
                if (rnd_q[MID-1]) begin
                    r_v = r_v + RND_INC;
                end
                s_v = r_v >>> D;
                x_v = {{(X_W-S_W){s_v[S_W-1]}}, s_v};
                if (sat_q[MID-1] && (x_v > MAX_X)) begin
                    res_d[ch]  = MAX_O;
                    flag_d[ch] = 1'b1;
                end else if (sat_q[MID-1] && (x_v < MIN_X)) begin
                    res_d[ch]  = MIN_O;
                    flag_d[ch] = 1'b1;
                end else begin
                    res_d[ch]  = x_v[O_W-1:0];
                    flag_d[ch] = 1'b0;
                end
            end
        end

        // A new saturation on the handshake beats a simultaneous clear.
        sticky_d = (sticky_q & ~{CHANNELS{sticky_clr}})
                 | ((out_valid_q && out_ready) ? flag_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            rnd_q       <= '0;
            sat_q       <= '0;
            for (int s = 0; s < MID; s++) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    prod_q[s][ch] <= '0;
                end
            end
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flag_q      <= '0;
            sticky_q    <= '0;
        end else begin
            vld_q       <= vld_d;
            rnd_q       <= rnd_d;
            sat_q       <= sat_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flag_q      <= flag_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out        = res_q;
    assign sat_flag   = flag_q;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_sfixed_mult_pipe.sv
// Scoreboard bench: two instances (default Q-format, and a narrow 3.4 output)
// share one stimulus stream; a negedge monitor checks results against a model.
module tb_sfixed_mult_pipe;

    localparam int CH = 3;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int O0 = 16;
    localparam int O1 = 8;
    localparam int D0 = 0;
    localparam int D1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, round_en, sat_en, out_ready, sticky_clr;
    logic [CH*AW-1:0]  a;
    logic [CH*BW-1:0]  b;
    logic              in_ready0, in_ready1, out_valid0, out_valid1;
    logic [CH*O0-1:0]  out0;
    logic [CH*O1-1:0]  out1;
    logic [CH-1:0]     flag0, flag1, sticky0, sticky1;

    sfixed_mult_pipe dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .round_en(round_en), .sat_en(sat_en),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
        .sat_flag(flag0), .sat_sticky(sticky0), .sticky_clr(sticky_clr)
    );

    sfixed_mult_pipe #(.OUT_LEFT(3), .OUT_RIGHT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .round_en(round_en), .sat_en(sat_en),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
        .sat_flag(flag1), .sat_sticky(sticky1), .sticky_clr(sticky_clr)
    );

    typedef struct {
        logic [CH*O0-1:0] o0;
        logic [CH-1:0]    f0;
        logic [CH*O1-1:0] o1;
        logic [CH-1:0]    f1;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [CH-1:0] st0_m = '0;
    logic [CH-1:0] st1_m = '0;
    int          rdy_mode = 0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact product, optional half-up bias, floor shift, clamp or wrap.
    function automatic void model(input longint av, input longint bv, input bit rnd,
                                  input bit sat, input int o_w, input int d,
                                  output longint o, output bit f);
        longint p, r, s, hi, lo;
        p = av * bv;
        r = p;
        if (rnd && d > 0) r = p + (longint'(1) << (d - 1));
        s  = r >>> d;
        hi = (longint'(1) << (o_w - 1)) - 1;
        lo = -hi - 1;
        o  = s;
        f  = 1'b0;
        if (sat && s > hi) begin
            o = hi; f = 1'b1;
        end else if (sat && s < lo) begin
            o = lo; f = 1'b1;
        end
    endfunction

    function automatic exp_t expect_beat(input logic [CH*AW-1:0] av, input logic [CH*BW-1:0] bv,
                                         input bit rnd, input bit sat);
        exp_t   e;
        longint o;
        bit     f;
        e.o0 = '0; e.f0 = '0; e.o1 = '0; e.f1 = '0;
        for (int i = 0; i < CH; i++) begin
            logic signed [AW-1:0] x;
            logic signed [BW-1:0] y;
            x = av[i*AW +: AW];
            y = bv[i*BW +: BW];
            model(x, y, rnd, sat, O0, D0, o, f);
            e.o0[i*O0 +: O0] = o[O0-1:0];
            e.f0[i] = f;
            model(x, y, rnd, sat, O1, D1, o, f);
            e.o1[i*O1 +: O1] = o[O1-1:0];
            e.f1[i] = f;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            st0_m = '0;
            st1_m = '0;
        end else begin
            chk("in_ready_rule", 64'(in_ready0), 64'(!out_valid0 || out_ready));
            chk("in_ready_lanes", 64'(in_ready1), 64'(in_ready0));
            chk("out_valid_lanes", 64'(out_valid1), 64'(out_valid0));
            chk("sticky0", 64'(sticky0), 64'(st0_m));
            chk("sticky1", 64'(sticky1), 64'(st1_m));
            if (sticky_clr) begin
                st0_m = '0;
                st1_m = '0;
            end
            if (out_valid0) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid0), 64'(0));
                end else begin
                    chk("out0", 64'(out0), 64'(q[0].o0));
                    chk("flag0", 64'(flag0), 64'(q[0].f0));
                    chk("out1", 64'(out1), 64'(q[0].o1));
                    chk("flag1", 64'(flag1), 64'(q[0].f1));
                    if (out_ready) begin
                        st0_m = st0_m | q[0].f0;
                        st1_m = st1_m | q[0].f1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CH*AW-1:0] av, input logic [CH*BW-1:0] bv,
                        input bit rnd, input bit sat, input bit clr);
        exp_t e;
        bit   ok;
        e  = expect_beat(av, bv, rnd, sat);
        ok = 1'b0;
        a = av; b = bv; round_en = rnd; sat_en = sat; sticky_clr = clr; in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready0) begin
                q.push_back(e);
                ok = 1'b1;
            end
            tick();
        end
        if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
        sticky_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int k;
        rdy_mode = 0;
        in_valid = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk("drain_left", 64'(q.size()), 64'(0));
        idle(2);
    endtask

    task automatic latency_beat(input logic [7:0] lane2_a, input logic [7:0] lane2_b);
        send({lane2_a, 8'hF0, 8'h18}, {lane2_b, 8'h08, 8'h24}, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", 64'(out_valid0), 64'(0));
        @(negedge clk);
        chk("lat_due", 64'(out_valid0), 64'(1));
        chk("ex_out0_l0", 64'(out0[15:0]), 64'(16'h0360));
        chk("ex_out0_l1", 64'(out0[31:16]), 64'(16'hFF80));
        chk("ex_flag0_l01", 64'(flag0[1:0]), 64'(0));
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; round_en = 1'b0; sat_en = 1'b0;
        sticky_clr = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid0), 64'(0));
        chk("rst_out", 64'(out0), 64'(0));
        chk("rst_flag", 64'(flag0), 64'(0));
        chk("rst_in_ready", 64'(in_ready0), 64'(1));
        tick();

        latency_beat(8'($urandom), 8'($urandom));
        drain();

        // Narrow-format rounding and saturation corners, all lanes alike.
        send({3{8'h01}}, {3{8'h08}}, 1'b1, 1'b0, 1'b0);
        send({3{8'h01}}, {3{8'h08}}, 1'b0, 1'b0, 1'b0);
        send({3{8'h7F}}, {3{8'h7F}}, 1'b0, 1'b1, 1'b0);
        send({3{8'h7F}}, {3{8'h7F}}, 1'b0, 1'b0, 1'b0);
        send({3{8'h80}}, {3{8'h7F}}, 1'b0, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        chk("sticky_set", 64'(sticky1), 64'(3'b111));
        tick();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 64'(sticky1), 64'(0));
        tick();

        rdy_mode = 1;
        for (int i = 0; i < 6; i++)
            send(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        drain();

        // Reset with two beats in flight: both must vanish.
        send(24'($urandom), 24'($urandom), 1'b0, 1'b1, 1'b0);
        send(24'($urandom), 24'($urandom), 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(out_valid0), 64'(0));
            tick();
        end
        latency_beat(8'($urandom), 8'($urandom));
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
